fmap_bank_ring: RTL and testbench

//  Parametrised N-bank ping-pong feature-map buffer controller for the CNN layer pipeline.
//  The producer (PE ofmap writer) fills one bank while the consumer (next-layer ifmap reader) drains another.

---
 rtl/fmap_bank_ring.sv | 134 +++++++++++++
 tb/tb_fmap_bank_ring.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_bank_ring.sv
// fmap_bank_ring: N-bank feature-map ring buffer controller.
// The producer fills bank wr_ptr and commits it; the consumer drains bank
// rd_ptr and releases it. External BRAMs have a 1-cycle read latency.
module fmap_bank_ring #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 12,
    parameter int NUM_BANKS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    output logic                          wr_ready,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_commit,
    input  logic [ADDR_W:0]               wr_len,
    output logic                          rd_ready,
    output logic [ADDR_W:0]               rd_len,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          rd_release,
    output logic [$clog2(NUM_BANKS):0]    full_cnt,
    output logic                          err_ovf,
    output logic                          err_udf,
    output logic [NUM_BANKS-1:0]          bank_we,
    output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   bank_din,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_dout
);

    localparam int PW = $clog2(NUM_BANKS);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   sel_d;
    logic [CW-1:0]   cnt;
    logic [ADDR_W:0] len_q [NUM_BANKS];

    logic            wr_acc;
    logic            rd_acc;
    logic            commit_acc;
    logic            rel_acc;
    logic [ADDR_W:0] len_clamped;

    // Ring pointers wrap at NUM_BANKS-1, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_BANKS - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_cnt    = cnt;
    assign wr_ready    = cnt < CW'(NUM_BANKS);
    assign rd_ready    = cnt != '0;
    // Word traffic is suppressed during flush so bank contents stay untouched.
    assign wr_acc      = wr_en & wr_ready & ~flush;
    assign rd_acc      = rd_en & rd_ready & ~flush;
    assign commit_acc  = wr_commit & wr_ready;
    assign rel_acc     = rd_release & rd_ready;
    assign len_clamped = (wr_len > DEPTH) ? DEPTH : wr_len;
    assign bank_din    = {NUM_BANKS{wr_data}};

    // Ring state: pointers, occupancy, committed lengths, sticky errors, read pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sel_d    <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANKS; i++) len_q[i] <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sel_d    <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANKS; i++) len_q[i] <= '0;
        end else begin
            if (commit_acc) begin
                len_q[wr_ptr] <= len_clamped;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (rel_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({commit_acc, rel_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if ((wr_en | wr_commit) & ~wr_ready) err_ovf <= 1'b1;
            if ((rd_en | rd_release) & ~rd_ready) err_udf <= 1'b1;
            rd_valid <= rd_acc;
            if (rd_acc) sel_d <= rd_ptr;
        end
    end

    // Per-bank port steering; producer and consumer banks never coincide when both are ready.
    always_comb begin
        bank_we   = '0;
        bank_addr = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (wr_acc && wr_ptr == PW'(i)) begin
                bank_we[i]                   = 1'b1;
                bank_addr[i*ADDR_W +: ADDR_W] = wr_addr;
            end else if (rd_acc && rd_ptr == PW'(i)) begin
                bank_addr[i*ADDR_W +: ADDR_W] = rd_addr;
            end
        end
    end

    // Read-data return mux, selected by the bank captured with the read.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (sel_d == PW'(i)) rd_data = bank_dout[i*DATA_W +: DATA_W];
        end
    end

    // Length of the consumer bank, forced to zero when nothing is committed.
    always_comb begin
        rd_len = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (rd_ready && rd_ptr == PW'(i)) rd_len = len_q[i];
        end
    end

endmodule

// File: tb/tb_fmap_bank_ring.sv
// Scoreboard bench for fmap_bank_ring with a 3-bank ring and read-first BRAM models.
module tb_fmap_bank_ring;

    localparam int NB    = 3;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(NB) + 1;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              wr_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_commit;
    logic [AW:0]       wr_len;
    logic              rd_ready;
    logic [AW:0]       rd_len;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_release;
    logic [CW-1:0]     full_cnt;
    logic              err_ovf;
    logic              err_udf;
    logic [NB-1:0]     bank_we;
    logic [NB*AW-1:0]  bank_addr;
    logic [NB*DW-1:0]  bank_din;
    logic [NB*DW-1:0]  bank_dout;

    int n_checks = 0;
    int n_fail   = 0;

    fmap_bank_ring #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_len(wr_len),
        .rd_ready(rd_ready), .rd_len(rd_len), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_release(rd_release),
        .full_cnt(full_cnt), .err_ovf(err_ovf), .err_udf(err_udf),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_din(bank_din), .bank_dout(bank_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External BRAMs: read-first, 1-cycle latency
    logic [DW-1:0] mem [NB][DEPTH];
    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (bank_we[i]) mem[i][bank_addr[i*AW +: AW]] <= bank_din[i*DW +: DW];
            bank_dout[i*DW +: DW] <= mem[i][bank_addr[i*AW +: AW]];
        end
    end

    // Reference model: ring as bank indices + occupancy, contents per bank
    int            m_wb, m_rb, m_cnt;
    int            m_len [NB];
    logic [DW-1:0] m_mem [NB][DEPTH];
    bit            m_ovf, m_udf;
    logic [DW-1:0] sb [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wb = 0; m_rb = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        for (int i = 0; i < NB; i++) m_len[i] = 0;
        sb.delete();
    endtask

    // Monitor: every negedge, a read accepted last cycle must be presented now
    always @(negedge clk) begin
        logic [DW-1:0] e;
        chk("rd_valid", rd_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (rd_valid) chk("rd_data", rd_data, e);
        end
    end

    // One clock of stimulus: drive, check combinational outputs, advance model
    task automatic cycle(input int we, input int wa, input int wd, input int wc, input int wl,
                         input int re, input int ra, input int rr, input int fl);
        bit            wrdy, rrdy;
        logic [NB-1:0] ewe;
        logic [NB*AW-1:0] eaddr;
        int            elen;
        @(negedge clk);
        wr_en = we[0]; wr_addr = AW'(wa); wr_data = DW'(wd); wr_commit = wc[0];
        wr_len = (AW+1)'(wl); rd_en = re[0]; rd_addr = AW'(ra); rd_release = rr[0];
        flush = fl[0];
        #1;
        wrdy = m_cnt < NB;
        rrdy = m_cnt > 0;
        ewe = '0; eaddr = '0;
        if (!fl[0] && we[0] && wrdy) begin
            ewe[m_wb] = 1'b1;
            eaddr[m_wb*AW +: AW] = AW'(wa);
        end
        if (!fl[0] && re[0] && rrdy) eaddr[m_rb*AW +: AW] = AW'(ra);
        elen = rrdy ? m_len[m_rb] : 0;
        chk("wr_ready", wr_ready, wrdy);
        chk("rd_ready", rd_ready, rrdy);
        chk("full_cnt", full_cnt, m_cnt);
        chk("rd_len", rd_len, elen);
        chk("bank_we", bank_we, ewe);
        chk("bank_addr", bank_addr, eaddr);
        chk("bank_din", bank_din, {NB{DW'(wd)}});
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_udf", err_udf, m_udf);
        if (fl[0]) begin
            model_clear();
        end else begin
            if (re[0]) begin
                if (rrdy) sb.push_back(m_mem[m_rb][ra % DEPTH]); else m_udf = 1;
            end
            if (we[0]) begin
                if (wrdy) m_mem[m_wb][wa % DEPTH] = DW'(wd); else m_ovf = 1;
            end
            if (wc[0]) begin
                if (wrdy) begin
                    m_len[m_wb] = (wl % 32 > DEPTH) ? DEPTH : wl % 32;
                    m_wb = (m_wb + 1) % NB;
                    m_cnt++;
                end else m_ovf = 1;
            end
            if (rr[0]) begin
                if (rrdy) begin
                    m_rb = (m_rb + 1) % NB;
                    m_cnt--;
                end else m_udf = 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic zero_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0; wr_len = '0;
        rd_en = 0; rd_addr = '0; rd_release = 0; flush = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 1'b1);
        chk({tag, "_rd_ready"}, rd_ready, 1'b0);
        chk({tag, "_full_cnt"}, full_cnt, 0);
        chk({tag, "_bank_we"}, bank_we, 0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_err_ovf"}, err_ovf, 1'b0);
        chk({tag, "_err_udf"}, err_udf, 1'b0);
        chk({tag, "_rd_len"}, rd_len, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released away from the active edge
    task automatic async_reset();
        @(negedge clk);
        #3;
        zero_inputs();
        rst_n = 1'b0;
        model_clear();
        #1;
        reset_checks("arst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) begin
                mem[b][a]   = '0;
                m_mem[b][a] = '0;
            end
        model_clear();
        #2;
        reset_checks("reset");
        #10;
        rst_n = 1'b1;

        // Basic write / commit / read
        for (int a = 0; a < 4; a++) cycle(1, a, 'hA0 + a, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 4, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 0, 0);
        idle(1);

        // Fill the ring, over-length commit clamps, rejected ops while full
        cycle(0, 0, 0, 1, 20, 0, 0, 0, 0);
        cycle(1, 0, 'hB0, 1, 9, 0, 0, 0, 0);
        cycle(1, 5, 'hCC, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // full_cnt=1: commit + release together, read of old bank in same cycle
        for (int a = 0; a < 5; a++) cycle(1, a, 'hD0 + a, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 5, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 3, 0, 0);
        idle(1);

        // Flush, then repeated rounds that wrap both pointers
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < 4; a++) cycle(1, a, 'h5000 + r * 16 + a, 0, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 1, 4, 0, 0, 0, 0);
            for (int a = 0; a < 3; a++) cycle(0, 0, 0, 0, 0, 1, a, 0, 0);
            cycle(0, 0, 0, 0, 0, 1, 3, 1, 0);
        end
        cycle(0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(2);

        // Async reset during a write burst with two banks committed
        cycle(1, 1, 'h1111, 1, 2, 0, 0, 0, 0);
        cycle(1, 2, 'h2222, 1, 3, 0, 0, 0, 0);
        for (int a = 0; a < 3; a++) cycle(1, a, 'h7700 + a, 0, 0, 0, 0, 0, 0);
        cycle(1, 3, 'h7703, 0, 0, 1, 1, 0, 0);
        async_reset();
        idle(2);

        // Flush with two banks committed and a read pending
        cycle(1, 0, 'h3333, 1, 1, 0, 0, 0, 0);
        cycle(1, 0, 'h4444, 1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 1, 'h9999, 0, 0, 1, 0, 0, 1);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 'hFFFF),
                  ($urandom_range(0, 5) == 0), $urandom_range(0, 31),
                  $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
        end
        idle(3);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
